// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: SLL/SRL/SRA/ROL/ROR with up to STEP positions per clock,
// valid/ready handshakes on both sides, carry-out and zero flags, abort of in-flight work.
module shift_unit_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             busy
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    localparam logic [SHW:0]     STEP_K = (SHW+1)'(STEP);
    localparam logic [SHW:0]     WIDTH_K = (SHW+1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             carry_reg;
    logic [2:0]       op_reg;
    logic [SHW-1:0]   rem_reg;
    logic             sign_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [SHW:0]     k;
    logic [SHW:0]     k_comp;
    logic [SHW-1:0]   rem_next;
    logic [WIDTH:0]   sll_t;
    logic [WIDTH:0]   srl_t;
    logic [WIDTH-1:0] rol_d;
    logic [WIDTH-1:0] ror_d;
    logic [WIDTH-1:0] sra_fill;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;
    logic             accept_pass;

    // One SHIFT cycle: move by k = min(STEP, rem). The extra guard bit in sll_t/srl_t
    // captures the last bit that falls off the end, which is the carry.
    always_comb begin
        k          = ({1'b0, rem_reg} > STEP_K) ? STEP_K : {1'b0, rem_reg};
        k_comp     = WIDTH_K - k;
        rem_next   = rem_reg - k[SHW-1:0];
        sll_t      = {1'b0, data_reg} << k;
        srl_t      = {data_reg, 1'b0} >> k;
        rol_d      = (data_reg << k) | (data_reg >> k_comp);
        ror_d      = (data_reg >> k) | (data_reg << k_comp);
        sra_fill   = sign_reg ? ~(ONES >> k) : '0;
        step_data  = data_reg;
        step_carry = carry_reg;
        case (op_reg)
            OP_SLL: begin
                step_data  = sll_t[WIDTH-1:0];
                step_carry = sll_t[WIDTH];
            end
            OP_SRL: begin
                step_data  = srl_t[WIDTH:1];
                step_carry = srl_t[0];
            end
            OP_SRA: begin
                step_data  = srl_t[WIDTH:1] | sra_fill;
                step_carry = srl_t[0];
            end
            OP_ROL: begin
                step_data  = rol_d;
                step_carry = rol_d[0];
            end
            OP_ROR: begin
                step_data  = ror_d;
                step_carry = ror_d[WIDTH-1];
            end
            default: begin
                step_data  = data_reg;
                step_carry = carry_reg;
            end
        endcase
    end

    assign accept_pass = (in_op > OP_ROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            carry_reg     <= 1'b0;
            op_reg        <= '0;
            rem_reg       <= '0;
            sign_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && !abort) begin
                        data_reg  <= in_data;
                        op_reg    <= in_op;
                        sign_reg  <= in_data[WIDTH-1];
                        carry_reg <= 1'b0;
                        rem_reg   <= accept_pass ? '0 : in_shamt;
                        busy_reg  <= 1'b1;
                        if (accept_pass || in_shamt == '0) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        data_reg  <= step_data;
                        carry_reg <= step_carry;
                        rem_reg   <= rem_next;
                        if (rem_next == '0) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // abort wins over out_ready; either way the result is released
                    if (abort || out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (state_reg == IDLE) && !abort;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_data  = data_reg;
    assign out_carry = carry_reg;
    assign out_zero  = (data_reg == '0);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: a STEP=1 and a STEP=4 instance, spec vectors from a table,
// hand-written abort/reset sequences, then random ops against a bit-serial reference model.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_data   [2];
    logic [3:0]  in_shamt  [2];
    logic [2:0]  in_op     [2];
    logic        abort     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_data  [2];
    logic        out_carry [2];
    logic        out_zero  [2];
    logic        busy      [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16), .SHW(4), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_shamt(in_shamt[0]), .in_op(in_op[0]), .abort(abort[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_carry(out_carry[0]), .out_zero(out_zero[0]), .busy(busy[0])
    );

    shift_unit_seq #(.WIDTH(16), .SHW(4), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_shamt(in_shamt[1]), .in_op(in_op[1]), .abort(abort[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_carry(out_carry[1]), .out_zero(out_zero[1]), .busy(busy[1])
    );

    typedef struct {
        int          u;
        logic [15:0] d;
        logic [3:0]  sh;
        logic [2:0]  op;
        int          hold;
        logic [15:0] ed;
        logic        ec;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: apply the operation one bit position at a time; result is independent of STEP.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] sh, input logic [2:0] op);
        logic [15:0] x = d;
        logic c = 1'b0;
        if (op > 3'd4) return {1'b0, d};
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                3'd0: begin c = x[15]; x = x * 2; end
                3'd1: begin c = x[0];  x = x / 2; end
                3'd2: begin c = x[0];  x = (x / 2) + (d[15] ? 16'h8000 : 16'h0); end
                3'd3: begin c = x[15]; x = (x * 2) + {15'd0, x[15]}; end
                default: begin c = x[0]; x = (x / 2) + (x[0] ? 16'h8000 : 16'h0); end
            endcase
        end
        return {c, x};
    endfunction

    task automatic run_op(input int u, input logic [15:0] d, input logic [3:0] sh, input logic [2:0] op,
                          input int hold, input logic [15:0] ed, input logic ec, input int elat);
        int n;
        int lat;
        logic [15:0] held_d;
        logic held_c;
        logic stable;
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_shamt[u] = sh;
        in_op[u]    = op;
        n = 0;
        while (!in_ready[u] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[u]) begin
            chk("accept_timeout", 32'(in_ready[u]), 32'd1);
            in_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_data[u]  = 16'($urandom);
        in_shamt[u] = 4'($urandom);
        in_op[u]    = 3'($urandom);
        while (!out_valid[u] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("u%0d op=%0d d=%h sh=%0d -> data=%h carry=%0d zero=%0d lat=%0d",
                 u, op, d, sh, out_data[u], out_carry[u], out_zero[u], lat);
        chk("latency", 32'(lat), 32'(elat));
        chk("out_data", 32'(out_data[u]), 32'(ed));
        chk("out_carry", 32'(out_carry[u]), 32'(ec));
        chk("out_zero", 32'(out_zero[u]), 32'(ed == 16'h0));
        chk("in_ready_in_done", 32'(in_ready[u]), 32'd0);
        held_d = out_data[u];
        held_c = out_carry[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable = out_valid[u] && !in_ready[u] && busy[u] && out_data[u] == held_d && out_carry[u] == held_c;
            chk("hold_stable", 32'(stable), 32'd1);
        end
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        chk("post_hs_valid", 32'(out_valid[u]), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready[u]), 32'd1);
    endtask

    initial begin
        logic [16:0] m;
        int u;
        int step;
        logic [15:0] d;
        logic [3:0] sh;
        logic [2:0] op;
        logic seen;

        tbl[0]  = '{0, 16'hAC57, 4'd2,  3'd0, 0, 16'hB15C, 1'b0, 3};
        tbl[1]  = '{0, 16'hAC57, 4'd3,  3'd1, 0, 16'h158A, 1'b1, 4};
        tbl[2]  = '{0, 16'hAC57, 4'd8,  3'd2, 0, 16'hFFAC, 1'b0, 9};
        tbl[3]  = '{0, 16'hAC57, 4'd4,  3'd4, 0, 16'h7AC5, 1'b0, 5};
        tbl[4]  = '{0, 16'hAC57, 4'd15, 3'd3, 0, 16'hD62B, 1'b1, 16};
        tbl[5]  = '{0, 16'hAC57, 4'd0,  3'd0, 5, 16'hAC57, 1'b0, 1};
        tbl[6]  = '{0, 16'h0001, 4'd1,  3'd1, 0, 16'h0000, 1'b1, 2};
        tbl[7]  = '{0, 16'hAC57, 4'd9,  3'd6, 2, 16'hAC57, 1'b0, 1};
        tbl[8]  = '{1, 16'hAC57, 4'd8,  3'd2, 0, 16'hFFAC, 1'b0, 3};
        tbl[9]  = '{1, 16'hAC57, 4'd5,  3'd3, 5, 16'h8AF5, 1'b1, 3};
        tbl[10] = '{1, 16'h0001, 4'd1,  3'd1, 0, 16'h0000, 1'b1, 2};

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 16'h0; in_shamt[i] = 4'h0;
            in_op[i] = 3'h0; abort[i] = 1'b0; out_ready[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(in_ready[i]), 32'd0);
            chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
            chk("rst_out_data", 32'(out_data[i]), 32'd0);
            chk("rst_out_zero", 32'(out_zero[i]), 32'd1);
            chk("rst_busy", 32'(busy[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_op(tbl[i].u, tbl[i].d, tbl[i].sh, tbl[i].op, tbl[i].hold, tbl[i].ed, tbl[i].ec, tbl[i].lat);

        // abort in IDLE blocks accept
        abort[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 16'h1234; in_shamt[0] = 4'd3; in_op[0] = 3'd0;
        #1 chk("abort_idle_in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("abort_idle_busy", 32'(busy[0]), 32'd0);
        abort[0] = 1'b0; in_valid[0] = 1'b0;
        $display("abort in IDLE: busy=%0d", busy[0]);

        // abort mid-SHIFT
        in_valid[0] = 1'b1; in_data[0] = 16'hAC57; in_shamt[0] = 4'd8; in_op[0] = 3'd2;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy[0]), 32'd1);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
        $display("abort mid-SHIFT: busy=%0d out_valid_seen=%0d", busy[0], seen);

        // abort in DONE wins over out_ready
        in_valid[0] = 1'b1; in_data[0] = 16'h00F0; in_shamt[0] = 4'd0; in_op[0] = 3'd0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("done_valid", 32'(out_valid[0]), 32'd1);
        abort[0] = 1'b1; out_ready[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0; out_ready[0] = 1'b0;
        chk("abort_done_valid", 32'(out_valid[0]), 32'd0);
        $display("abort in DONE: out_valid=%0d", out_valid[0]);

        // reset mid-SHIFT
        in_valid[0] = 1'b1; in_data[0] = 16'hAC57; in_shamt[0] = 4'd6; in_op[0] = 3'd1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", 32'(out_data[0]), 32'd0);
        chk("rst_mid_carry", 32'(out_carry[0]), 32'd0);
        chk("rst_mid_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready[0]), 32'd0);
        chk("rst_mid_zero", 32'(out_zero[0]), 32'd1);
        $display("reset mid-SHIFT: data=%h busy=%0d", out_data[0], busy[0]);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            u = int'($urandom_range(0, 1));
            step = (u == 0) ? 1 : 4;
            d  = 16'($urandom);
            sh = 4'($urandom);
            op = 3'($urandom);
            m  = model(d, sh, op);
            run_op(u, d, sh, op, int'($urandom_range(0, 2)), m[15:0], m[16],
                   (op > 3'd4) ? 1 : 1 + (int'(sh) + step - 1) / step);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
